conf_int_mul_pipe_multimode: RTL and testbench
==============================================

// Module: conf_int_mul_pipe_multimode
// PURPOSE
//  Next-generation configurable-accuracy signed integer multiplier for the IDCT datapath.
//  Replaces state-decoded operand latching with a per-operation mode and a valid/ready pipeline.
//  Approximate modes zero APX_BITS operand LSBs. Output is scaled, rounded, saturated and
//  optionally accumulated (MAC). Sits between the IDCT coefficient sequencer and the row/column buffers.
// PARAMETERS
//  DATA_PATH_BITWIDTH  24  operand width (two's complement)
//  APX_BITS             8  operand LSBs forced to 0 in approximate modes (1..DATA_PATH_BITWIDTH-1)
//  OUT_BITWIDTH        32  result width
//  OUT_SHIFT           11  arithmetic right shift applied to the product (>=1)
// PORTS
//  clk        in   1                     rising-edge clock
//  rstN       in   1                     asynchronous active-low reset
//  in_valid   in   1                     operand beat valid
//  in_ready   out  1                     block can accept a beat
//  a          in   DATA_PATH_BITWIDTH    operand A, signed
//  b          in   DATA_PATH_BITWIDTH    operand B, signed
//  mode       in   2                     00 accurate, 01 APX_A, 10 APX_AB, 11 reserved (= accurate)
//  acc_en     in   1                     1: add to accumulator; 0: plain multiply
//  acc_first  in   1                     with acc_en: reload accumulator instead of adding
//  out_valid  out  1                     result valid
//  out_ready  in   1                     downstream accepts result
//  P          out  OUT_BITWIDTH          scaled/rounded/saturated result or running sum
//  sat        out  1                     this result saturated
//  sat_sticky out  1                     any saturation since reset; cleared by accepted acc_first beat
// BEHAVIOUR
//  Reset (rstN=0, async): all valids 0, P=0, sat=0, sat_sticky=0, accumulator=0, in_ready=1 after release.
//  Pipeline: S1 masked operands + ctrl; S2 full 2*DATA_PATH_BITWIDTH signed product; S3 scale/round/sat/acc.
//  Latency exactly 3 cycles from accepted beat to out_valid with no backpressure; throughput 1/cycle.
//  Accept on in_valid & in_ready. Stall = out_valid & ~out_ready; the whole pipe freezes on stall.
//  in_ready = ~stall (combinational). P/sat hold stable while out_valid & ~out_ready.
//  Bubbles (invalid stages) advance during non-stall cycles; they do not touch the accumulator.
//  Masking: APX_A zeroes a[APX_BITS-1:0]; APX_AB zeroes low APX_BITS of both a and b.
//  Scaling: r = (prod + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT (round half up), full precision, no overflow.
//  acc_en=0: P = sat(r). acc_en=1 & acc_first=1: acc = sat(r). acc_en=1 & acc_first=0: acc = sat(acc + r).
//  acc_en=1: P = new acc value.
//  sat(x): clamp to [-2^(OUT_BITWIDTH-1), 2^(OUT_BITWIDTH-1)-1]; sat=1 iff the clamp changed the value.
//  Accumulator updates only when its beat leaves S3 into the output register (once per beat, never while stalled).
//  Simultaneous sat on a reloading beat: the beat clears sat_sticky, then sets it (sticky ends 1).
//  Reset mid-operation: in-flight beats discarded, no out_valid generated for them.
// TESTING
//  1 accurate: a=0x0008FF, b=0x000180, mode=00 -> P=432 (0x1B0) 3 cycles later, sat=0.
//  2 APX_A: same operands, mode=01 -> P=384; APX_AB: mode=10 -> P=256.
//  3 sign/sat: a=0xFFF800, b=0x000180 -> P=0xFFFFFE80; a=b=0x7FFFFF -> P=0x7FFFFFFF, sat=1, sat_sticky=1.
//  4 MAC: 4 beats a=0x000800, b=4/8/12/16, acc_en=1, acc_first=1 on first -> P=4,12,24,40.
//  5 backpressure: stream 8 beats, hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 during stall;
//    P stable; all 8 results in order, none lost or duplicated; MAC sum unchanged vs no-stall run.
//  6 reset: assert rstN=0 with 2 beats in flight -> outputs 0 immediately; no stale out_valid after release.

Source files
------------

// File: rtl/conf_int_mul_pipe_multimode.sv
// Configurable-accuracy signed multiplier with scale/round/saturate and optional MAC for the IDCT datapath.
// Latency 3 cycles, throughput 1/cycle; the whole pipe freezes while the output is held (in_ready = ~stall).
module conf_int_mul_pipe_multimode #(
    parameter int DATA_PATH_BITWIDTH = 24,
    parameter int APX_BITS           = 8,
    parameter int OUT_BITWIDTH       = 32,
    parameter int OUT_SHIFT          = 11
) (
    input  logic                          clk,
    input  logic                          rstN,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_PATH_BITWIDTH-1:0] a,
    input  logic [DATA_PATH_BITWIDTH-1:0] b,
    input  logic [1:0]                    mode,
    input  logic                          acc_en,
    input  logic                          acc_first,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_BITWIDTH-1:0]       P,
    output logic                          sat,
    output logic                          sat_sticky
);
    localparam int DW = DATA_PATH_BITWIDTH;
    localparam int OW = OUT_BITWIDTH;
    localparam int PW = 2 * DW;
    localparam int RW = PW + 1 - OUT_SHIFT;
    localparam int SW = ((RW > OW) ? RW : OW) + 1;

    localparam logic [DW-1:0]        APX_MASK = {{(DW-APX_BITS){1'b1}}, {APX_BITS{1'b0}}};
    localparam logic signed [PW:0]   RND      = (PW+1)'(1) << (OUT_SHIFT - 1);
    localparam logic signed [SW-1:0] MAXV     = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV     = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    logic stall;
    logic adv;

    assign stall    = out_valid & ~out_ready;
    assign adv      = ~stall;
    assign in_ready = ~stall;

    logic [DW-1:0] a_m;
    logic [DW-1:0] b_m;

    always_comb begin
        a_m = a;
        b_m = b;
        if (mode == 2'b01 || mode == 2'b10) a_m = a & APX_MASK;
        if (mode == 2'b10)                  b_m = b & APX_MASK;
    end

    // S1: masked operands and per-beat control
    logic                 v1, en1, first1;
    logic signed [DW-1:0] a1, b1;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            v1     <= 1'b0;
            en1    <= 1'b0;
            first1 <= 1'b0;
            a1     <= '0;
            b1     <= '0;
        end else if (adv) begin
            v1     <= in_valid;
            en1    <= acc_en;
            first1 <= acc_first;
            a1     <= a_m;
            b1     <= b_m;
        end
    end

    // S2: full-precision signed product
    logic                 v2, en2, first2;
    logic signed [PW-1:0] prod2;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            v2     <= 1'b0;
            en2    <= 1'b0;
            first2 <= 1'b0;
            prod2  <= '0;
        end else if (adv) begin
            v2     <= v1;
            en2    <= en1;
            first2 <= first1;
            prod2  <= a1 * b1;
        end
    end

    // S3: round-half-up scaling, optional accumulate, saturation
    logic signed [PW:0]   rnd_sum;
    logic signed [RW-1:0] r;
    logic signed [SW-1:0] r_ext, acc_ext, sum_x;
    logic signed [OW-1:0] acc;
    logic [OW-1:0]        res;
    logic                 sat_n;

    always_comb begin
        rnd_sum = prod2 + RND;
        r       = RW'(rnd_sum >>> OUT_SHIFT);
        r_ext   = SW'(r);
        acc_ext = SW'(acc);
        sum_x   = (en2 && !first2) ? acc_ext + r_ext : r_ext;
        sat_n   = 1'b0;
        res     = sum_x[OW-1:0];
        if (sum_x > MAXV) begin
            res   = MAXV[OW-1:0];
            sat_n = 1'b1;
        end else if (sum_x < MINV) begin
            res   = MINV[OW-1:0];
            sat_n = 1'b1;
        end
    end

    // Output register; accumulator and sticky flag only move when a valid beat retires
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            out_valid  <= 1'b0;
            P          <= '0;
            sat        <= 1'b0;
            sat_sticky <= 1'b0;
            acc        <= '0;
        end else if (adv) begin
            out_valid <= v2;
            if (v2) begin
                P          <= res;
                sat        <= sat_n;
                sat_sticky <= ((en2 && first2) ? 1'b0 : sat_sticky) | sat_n;
                if (en2) acc <= res;
            end
        end
    end
endmodule

// File: tb/tb_conf_int_mul_pipe_multimode.sv
// Directed bench for conf_int_mul_pipe_multimode: a behavioural reference model plus literal pins.
module tb_conf_int_mul_pipe_multimode;
    logic        clk = 1'b0;
    logic        rstN;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [23:0] a, b;
    logic [1:0]  mode;
    logic        acc_en, acc_first;
    logic [31:0] P;
    logic        sat, sat_sticky;

    conf_int_mul_pipe_multimode dut (
        .clk(clk), .rstN(rstN), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .acc_en(acc_en), .acc_first(acc_first),
        .out_valid(out_valid), .out_ready(out_ready), .P(P), .sat(sat), .sat_sticky(sat_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] p;
        logic        s;
        logic        st;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] obs_p[$];
    logic        obs_s[$];
    logic        obs_st[$];
    longint      m_acc;
    logic        m_sticky;
    int          total, bad, cyc, n_out;
    logic        lat_chk;
    logic        prev_stall;
    logic [31:0] prev_p;
    logic        prev_sat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the beat, in acceptance order
    function automatic exp_t model(input logic [23:0] ia, input logic [23:0] ib,
                                   input logic [1:0] im, input logic ie, input logic ifst);
        exp_t   e;
        longint sa, sb, prod, r, x;
        logic   s;
        sa = longint'($signed(ia));
        sb = longint'($signed(ib));
        if (im == 2'd1 || im == 2'd2) sa = (sa >>> 8) <<< 8;
        if (im == 2'd2)               sb = (sb >>> 8) <<< 8;
        prod = sa * sb;
        r    = (prod + 1024) >>> 11;
        x    = (ie && !ifst) ? m_acc + r : r;
        s    = 1'b0;
        if (x > 64'sd2147483647)  begin x = 64'sd2147483647;  s = 1'b1; end
        if (x < -64'sd2147483648) begin x = -64'sd2147483648; s = 1'b1; end
        if (ie) m_acc = x;
        if (ie && ifst) m_sticky = 1'b0;
        m_sticky = m_sticky | s;
        e.p   = x[31:0];
        e.s   = s;
        e.st  = m_sticky;
        e.cyc = cyc;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (rstN) begin
            check("in_ready", {63'd0, in_ready}, {63'd0, !(out_valid && !out_ready)});
            if (prev_stall && out_valid) begin
                check("hold_P", {32'd0, P}, {32'd0, prev_p});
                check("hold_sat", {63'd0, sat}, {63'd0, prev_sat});
            end
            if (out_valid && out_ready) begin
                n_out++;
                obs_p.push_back(P);
                obs_s.push_back(sat);
                obs_st.push_back(sat_sticky);
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got P=0x%0h with no beat pending", P);
                end else begin
                    e = q.pop_front();
                    check("P", {32'd0, P}, {32'd0, e.p});
                    check("sat", {63'd0, sat}, {63'd0, e.s});
                    check("sat_sticky", {63'd0, sat_sticky}, {63'd0, e.st});
                    if (lat_chk) check("latency", 64'(cyc - e.cyc), 64'd3);
                end
            end
            if (in_valid && in_ready) q.push_back(model(a, b, mode, acc_en, acc_first));
            prev_stall = out_valid && !out_ready;
            prev_p     = P;
            prev_sat   = sat;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send(input logic [23:0] ia, input logic [23:0] ib, input logic [1:0] im,
                        input logic ie, input logic ifst);
        logic ok;
        a = ia; b = ib; mode = im; acc_en = ie; acc_first = ifst;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        check("drain_empty", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic mac8();
        for (int k = 1; k <= 8; k++) send(24'h000800, 24'(4 * k), 2'b00, 1'b1, k == 1);
    endtask

    initial begin
        int base;
        total = 0; bad = 0; cyc = 0; n_out = 0;
        m_acc = 0; m_sticky = 1'b0; lat_chk = 1'b1; prev_stall = 1'b0;
        prev_p = '0; prev_sat = 1'b0;
        rstN = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; mode = '0; acc_en = 1'b0; acc_first = 1'b0;
        #2 rstN = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstN = 1'b1;
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_P", {32'd0, P}, 64'd0);
        check("rst_sat", {63'd0, sat}, 64'd0);
        check("rst_sticky", {63'd0, sat_sticky}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;

        // Mode, sign and saturation vectors
        base = obs_p.size();
        send(24'h0008FF, 24'h000180, 2'b00, 1'b0, 1'b0);
        send(24'h0008FF, 24'h000180, 2'b01, 1'b0, 1'b0);
        send(24'h0008FF, 24'h000180, 2'b10, 1'b0, 1'b0);
        send(24'hFFF800, 24'h000180, 2'b00, 1'b0, 1'b0);
        send(24'h7FFFFF, 24'h7FFFFF, 2'b00, 1'b0, 1'b0);
        drain();
        check("lit_accurate", {32'd0, obs_p[base]}, 64'd432);
        check("lit_accurate_sat", {63'd0, obs_s[base]}, 64'd0);
        check("lit_apx_a", {32'd0, obs_p[base+1]}, 64'd384);
        check("lit_apx_ab", {32'd0, obs_p[base+2]}, 64'd256);
        check("lit_negative", {32'd0, obs_p[base+3]}, 64'hFFFFFE80);
        check("lit_sat_P", {32'd0, obs_p[base+4]}, 64'h7FFFFFFF);
        check("lit_sat", {63'd0, obs_s[base+4]}, 64'd1);
        check("lit_sticky", {63'd0, obs_st[base+4]}, 64'd1);

        // MAC: reload clears the sticky flag left by the saturated beat
        base = obs_p.size();
        send(24'h000800, 24'd4, 2'b00, 1'b1, 1'b1);
        send(24'h000800, 24'd8, 2'b00, 1'b1, 1'b0);
        send(24'h000800, 24'd12, 2'b00, 1'b1, 1'b0);
        send(24'h000800, 24'd16, 2'b00, 1'b1, 1'b0);
        drain();
        check("lit_mac0", {32'd0, obs_p[base]}, 64'd4);
        check("lit_mac1", {32'd0, obs_p[base+1]}, 64'd12);
        check("lit_mac2", {32'd0, obs_p[base+2]}, 64'd24);
        check("lit_mac3", {32'd0, obs_p[base+3]}, 64'd40);
        check("lit_mac_sticky", {63'd0, obs_st[base+3]}, 64'd0);

        // Backpressure: same 8-beat MAC without and with a 5-cycle stall
        base = n_out;
        mac8();
        drain();
        check("nostall_count", 64'(n_out - base), 64'd8);
        check("nostall_sum", {32'd0, obs_p[obs_p.size()-1]}, 64'd144);
        lat_chk = 1'b0;
        base = n_out;
        fork
            mac8();
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_in_ready", {63'd0, in_ready}, 64'd0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("stall_count", 64'(n_out - base), 64'd8);
        check("stall_sum", {32'd0, obs_p[obs_p.size()-1]}, 64'd144);
        lat_chk = 1'b1;

        // Reset with two beats in flight
        base = n_out;
        send(24'h000800, 24'd100, 2'b00, 1'b0, 1'b0);
        send(24'h000800, 24'd200, 2'b00, 1'b0, 1'b0);
        rstN = 1'b0;
        #1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_P", {32'd0, P}, 64'd0);
        check("midrst_sticky", {63'd0, sat_sticky}, 64'd0);
        q.delete();
        m_acc = 0;
        m_sticky = 1'b0;
        @(posedge clk);
        #1 rstN = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("midrst_no_stale", 64'(n_out - base), 64'd0);
        check("midrst_idle_valid", {63'd0, out_valid}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
